iter_multiplier: RTL and testbench

//  Parametrised iterative multiplier-accumulator for the Execute stage. It serves MUL, MLA,

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mult_step.sv | 22 ++
 rtl/iter_multiplier.sv | 136 +++++++++++++
 tb/tb_iter_multiplier.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier-accumulator.
package mult_pkg;

  localparam int DEFAULT_WIDTH          = 32;
  localparam int DEFAULT_BITS_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  // Number of RUN cycles needed to scan the whole multiplier.
  function automatic int steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Width of a counter that can hold 0..n.
  function automatic int step_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One RUN-cycle slice: adds the partial products selected by BITS_PER_CYCLE multiplier bits.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic [BITS_PER_CYCLE-1:0] mplier,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [2*WIDTH-1:0]        prod,
  output logic [2*WIDTH-1:0]        prod_next
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    prod_next = prod;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) prod_next = prod_next + (mcand << i);
    end
  end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative multiply-accumulate (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL) with N/Z flags.
// Define MULT_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier is zero.
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic               long_op,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic               abort,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_n,
  output logic               flag_z
);

  localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = step_cnt_width(STEPS);
  localparam int DW    = 2 * WIDTH;

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("iter_multiplier: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e          state, state_next;
  logic [WIDTH-1:0] mplier;
  logic [DW-1:0]    mcand;
  logic [DW-1:0]    prod;
  logic [DW-1:0]    acc;
  logic             neg;
  logic             long_q;
  logic [CW-1:0]    step_cnt;

  logic [DW-1:0]    prod_step;
  logic [WIDTH-1:0] mag0, mag1;
  logic             accept;
  logic             run_last;
  logic [DW-1:0]    fix_res;
  logic             fix_n, fix_z;

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mplier    (mplier[BITS_PER_CYCLE-1:0]),
    .mcand     (mcand),
    .prod      (prod),
    .prod_next (prod_step)
  );

  // Signed operands are reduced to magnitudes; 2^(W-1) still fits in W unsigned bits.
  always_comb begin
    mag0 = (signed_op && in0[WIDTH-1]) ? -in0 : in0;
    mag1 = (signed_op && in1[WIDTH-1]) ? -in1 : in1;
  end

  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    run_last = (step_cnt == CW'(STEPS - 1)) || ((mplier >> BITS_PER_CYCLE) == '0);
`else
    run_last = (step_cnt == CW'(STEPS - 1));
`endif
  end

  always_comb begin
    state_next = state;
    ready      = (state == IDLE) || (state == DONE);
    busy       = (state == RUN)  || (state == FIX);
    done       = (state == DONE);
    accept     = start && ready && !abort;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (run_last) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    fix_res = (neg ? -prod : prod) + acc;
    if (!long_q) fix_res[DW-1:WIDTH] = '0;
    fix_n = long_q ? fix_res[DW-1] : fix_res[WIDTH-1];
    fix_z = (fix_res == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b1;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      long_q   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mplier   <= mag0;
        mcand    <= {{WIDTH{1'b0}}, mag1};
        prod     <= '0;
        acc      <= long_op ? acc_in : {{WIDTH{1'b0}}, acc_in[WIDTH-1:0]};
        neg      <= signed_op && (in0[WIDTH-1] ^ in1[WIDTH-1]);
        long_q   <= long_op;
        step_cnt <= '0;
      end else if (state == RUN) begin
        mplier   <= mplier >> BITS_PER_CYCLE;
        mcand    <= mcand << BITS_PER_CYCLE;
        prod     <= prod_step;
        step_cnt <= step_cnt + 1'b1;
      end
      // An abort during FIX must leave the previous result visible.
      if (state == FIX && !abort) begin
        result <= fix_res;
        flag_n <= fix_n;
        flag_z <= fix_z;
      end
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (W=32, B=2); reference model uses plain 64-bit arithmetic.
// Latency expectations follow MULT_EARLY_TERM_EN when it is defined for the build.
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        long_op = 1'b0;
  logic [63:0] acc_in = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        abort = 1'b0;
  logic        ready, busy, done, flag_n, flag_z;
  logic [63:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res = '0;
  logic        last_n = 1'b0;
  logic        last_z = 1'b1;

  iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .long_op   (long_op),
    .acc_in    (acc_in),
    .in0       (in0),
    .in1       (in1),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input bit s, input bit l, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p, r;
    longint      sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    r = p + acc;
    if (!l) r = {32'h0, r[31:0]};
    return r;
  endfunction

  // Cycles from the accepting edge (counted as 1) to the edge that raises done.
  function automatic int ref_latency(input bit s, input logic [31:0] a);
    logic [31:0] m;
    int          n;
    m = (s && a[31]) ? (32'h0 - a) : a;
    n = 0;
    do begin
      m = m >> 2;
      n++;
    end while (m != 0 && n < 16);
`ifdef MULT_EARLY_TERM_EN
    return n + 2;
`else
    return (n > 0) ? 18 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
      start = 1'b0;
    end
  endtask

  task automatic expect_done(input string tag, input bit s, input bit l, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] exp_r;
    int          lat;
    exp_r = ref_result(s, l, a, b, acc);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(ref_latency(s, a)));
    check({tag, "_result"}, result, exp_r);
    check({tag, "_flag_n"}, 64'(flag_n), 64'(l ? exp_r[63] : exp_r[31]));
    check({tag, "_flag_z"}, 64'(flag_z), 64'(exp_r == 64'h0));
    last_res = exp_r;
    last_n   = l ? exp_r[63] : exp_r[31];
    last_z   = (exp_r == 64'h0);
  endtask

  task automatic launch(input bit s, input bit l, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, input bit poke_start);
    start = 1'b1; signed_op = s; long_op = l; in0 = a; in1 = b; acc_in = acc;
    tick();
    // Scramble every input after acceptance; the latched operation must be unaffected.
    start     = poke_start;
    in0       = $urandom;
    in1       = $urandom;
    acc_in    = {$urandom, $urandom};
    signed_op = 1'($urandom);
    long_op   = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input bit s, input bit l, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input bit poke_start);
    launch(s, l, a, b, acc, poke_start);
    check({tag, "_ready_low"}, 64'(ready), 64'(0));
    check({tag, "_busy_high"}, 64'(busy), 64'(1));
    expect_done(tag, s, l, a, b, acc);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_ready_after"}, 64'(ready), 64'(1));
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check({tag, "_no_done"}, 64'(seen), 64'(0));
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_ready"}, 64'(ready), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_result"}, result, last_res);
    check({tag, "_flag_n"}, 64'(flag_n), 64'(last_n));
    check({tag, "_flag_z"}, 64'(flag_z), 64'(last_z));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] acc;
    bit          s, l;
    int          lat;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_idle_state("reset");

    // Directed cases
    run_op("u_short_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 64'd0, 1'b0);
    run_op("s_long_m3x5", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'd0, 1'b1);
    run_op("s_long_minxmin", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'd0, 1'b0);
    run_op("u_short_mla", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'hDEAD_BEEF_0000_0064, 1'b0);
    run_op("zero_mplier", 1'b0, 1'b0, 32'd0, 32'h1234, 64'd0, 1'b0);
    run_op("u_long_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("s_short_neg", 1'b1, 1'b0, 32'd1000, 32'hFFFF_FFF9, 64'd0, 1'b0);

    // Abort in RUN cycle 5: no done, previous result kept
    launch(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 64'd0, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_state("abort_run");
    expect_quiet("abort_run", 25);
    run_op("after_abort_9x9", 1'b0, 1'b0, 32'd9, 32'd9, 64'd0, 1'b0);

    // Abort in IDLE drops a simultaneous start
    start = 1'b1; abort = 1'b1; in0 = 32'd5; in1 = 32'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle_state("abort_idle");
    expect_quiet("abort_idle", 22);

    // Back-to-back: a start held in DONE is accepted immediately
    launch(1'b0, 1'b0, 32'd123, 32'd456, 64'd0, 1'b0);
    expect_done("b2b_first", 1'b0, 1'b0, 32'd123, 32'd456, 64'd0);
    start = 1'b1; signed_op = 1'b1; long_op = 1'b1;
    in0 = 32'hFFFF_FFF9; in1 = 32'd1000; acc_in = 64'd77;
    tick();
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    expect_done("b2b_second", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd1000, 64'd77);
    tick();

    // Reset mid-RUN returns every output to its reset value
    launch(1'b0, 1'b1, 32'hABCD_1234, 32'h5678_9ABC, 64'd0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_res = 64'h0; last_n = 1'b0; last_z = 1'b1;
    check_idle_state("rst_mid_run");
    expect_quiet("rst_mid_run", 22);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      s   = 1'($urandom);
      l   = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b   = $urandom;
      acc = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
      run_op($sformatf("rand%0d", i), s, l, a, b, acc, 1'($urandom));
    end

    // Bounded check that the bench still sees a quiet idle design
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("final_ready", 64'(ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
